// File: rtl/el2_dccm_arb_pkg.sv
// Shared types and constants for the DCCM lo-bank port arbiter.
package el2_dccm_arb_pkg;

    // Arbiter FSM states; StDmaLock is only reachable with DCCM_ARB_DMA_LOCK_EN.
    typedef enum logic [1:0] {
        StNorm    = 2'd0,
        StDmaPri  = 2'd1,
        StDmaLock = 2'd2
    } arb_state_e;

    // Which requester issued the read that is currently outstanding.
    typedef enum logic {
        OwnLsu = 1'b0,
        OwnDma = 1'b1
    } owner_e;

    // Maximum number of consecutive cycles DMA may hold the port locked.
    localparam int unsigned DmaLockMax = 16;

endpackage

// File: rtl/el2_dccm_arb_rdtrk.sv
// Read-return tracker: remembers whether a read is in flight and who issued it,
// then steers the DCCM read data to that requester one cycle later.
module el2_dccm_arb_rdtrk
    import el2_dccm_arb_pkg::*;
#(
    parameter int unsigned DCCM_FDATA_WIDTH = 39
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rden,
    input  owner_e                      rd_own,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic                        lsu_rvalid,
    output logic [DCCM_FDATA_WIDTH-1:0] lsu_rdata,
    output logic                        dma_rvalid,
    output logic [DCCM_FDATA_WIDTH-1:0] dma_rdata
);

    logic   rd_pend_q;
    owner_e rd_own_q;

    // Capture the read strobe and its owner; reset drops any return in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= OwnLsu;
        end else begin
            rd_pend_q <= rden;
            rd_own_q  <= rd_own;
        end
    end

    // Tag the returning data; the non-owner sees zeros.
    always_comb begin
        lsu_rvalid = !rst && rd_pend_q && (rd_own_q == OwnLsu);
        dma_rvalid = !rst && rd_pend_q && (rd_own_q == OwnDma);
        lsu_rdata  = lsu_rvalid ? dccm_rd_data_lo : '0;
        dma_rdata  = dma_rvalid ? dccm_rd_data_lo : '0;
    end

endmodule

// File: rtl/el2_dccm_port_arb.sv
// LSU/DMA arbiter and sequencer for the DCCM lo-bank port.
// LSU has default priority; DMA is promoted after DMA_STARVE_MAX blocked cycles.
// Optional feature: define DCCM_ARB_DMA_LOCK_EN to add the dma_lock input and a
// locked-DMA state that holds the port for at most DmaLockMax cycles.
module el2_dccm_port_arb
    import el2_dccm_arb_pkg::*;
#(
    parameter int unsigned DCCM_BITS        = 16,
    parameter int unsigned DCCM_FDATA_WIDTH = 39,
    parameter int unsigned DMA_STARVE_MAX   = 8
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        lsu_req,
    input  logic                        lsu_wr,
    input  logic [DCCM_BITS-1:0]        lsu_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata,
    output logic                        lsu_gnt,
    output logic                        lsu_rvalid,
    output logic [DCCM_FDATA_WIDTH-1:0] lsu_rdata,

    input  logic                        dma_req,
    input  logic                        dma_wr,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
`ifdef DCCM_ARB_DMA_LOCK_EN
    input  logic                        dma_lock,
`endif
    output logic                        dma_gnt,
    output logic                        dma_rvalid,
    output logic [DCCM_FDATA_WIDTH-1:0] dma_rdata,

    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,

    output logic                        dma_starved
);

    localparam logic [7:0] StarveMax = 8'(DMA_STARVE_MAX);

    arb_state_e state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       dma_blocked;
    logic [DCCM_BITS-1:0] sel_addr;

`ifdef DCCM_ARB_DMA_LOCK_EN
    localparam int unsigned LockCntW = $clog2(DmaLockMax);
    logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
    logic                lock_timeout;
`endif

    // State, starvation counter and lock counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StNorm;
            starve_cnt_q <= 8'd0;
`ifdef DCCM_ARB_DMA_LOCK_EN
            lock_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
`ifdef DCCM_ARB_DMA_LOCK_EN
            lock_cnt_q   <= lock_cnt_d;
`endif
        end
    end

    // Grant decision: at most one winner per cycle, nothing while in reset.
    always_comb begin
        lsu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            case (state_q)
                StNorm: begin
                    if (lsu_req)      lsu_gnt = 1'b1;
                    else if (dma_req) dma_gnt = 1'b1;
                end
                StDmaPri: begin
                    if (dma_req)      dma_gnt = 1'b1;
                    else if (lsu_req) lsu_gnt = 1'b1;
                end
`ifdef DCCM_ARB_DMA_LOCK_EN
                // LSU is shut out even if DMA idles while locked.
                StDmaLock: dma_gnt = dma_req;
`endif
                default: ;
            endcase
        end
    end

    assign dma_blocked = dma_req && !dma_gnt;

`ifdef DCCM_ARB_DMA_LOCK_EN
    assign lock_timeout = (lock_cnt_q == LockCntW'(DmaLockMax - 1));
`endif

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StNorm: begin
                if (dma_blocked && (starve_cnt_q >= StarveMax - 8'd1)) state_d = StDmaPri;
            end
            StDmaPri: begin
                if (dma_gnt || !dma_req) state_d = StNorm;
            end
`ifdef DCCM_ARB_DMA_LOCK_EN
            StDmaLock: begin
                if (lock_timeout || !dma_lock) state_d = StNorm;
            end
`endif
            default: state_d = StNorm;
        endcase
`ifdef DCCM_ARB_DMA_LOCK_EN
        // A locked DMA grant (re)enters the lock unless the lock just timed out.
        if (dma_gnt && dma_lock && !(state_q == StDmaLock && lock_timeout)) begin
            state_d = StDmaLock;
        end
        lock_cnt_d = (state_q == StDmaLock) ? lock_cnt_q + LockCntW'(1) : '0;
`endif

        if (!dma_req || dma_gnt)          starve_cnt_d = 8'd0;
        else if (starve_cnt_q < StarveMax) starve_cnt_d = starve_cnt_q + 8'd1;
        else                               starve_cnt_d = starve_cnt_q;
    end

    // DCCM strobes and address/data muxing; idle ports drive zeros.
    always_comb begin
        sel_addr        = dma_gnt ? dma_addr : lsu_addr;
        dccm_wren       = (lsu_gnt && lsu_wr) || (dma_gnt && dma_wr);
        dccm_rden       = (lsu_gnt && !lsu_wr) || (dma_gnt && !dma_wr);
        dccm_wr_addr_lo = dccm_wren ? sel_addr : '0;
        dccm_rd_addr_lo = dccm_rden ? sel_addr : '0;
        dccm_wr_data_lo = '0;
        if (dccm_wren) dccm_wr_data_lo = dma_gnt ? dma_wdata : lsu_wdata;
        dma_starved     = (state_q == StDmaPri);
    end

    el2_dccm_arb_rdtrk #(
        .DCCM_FDATA_WIDTH(DCCM_FDATA_WIDTH)
    ) u_rdtrk (
        .clk            (clk),
        .rst            (rst),
        .rden           (dccm_rden),
        .rd_own         (dma_gnt ? OwnDma : OwnLsu),
        .dccm_rd_data_lo(dccm_rd_data_lo),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rdata      (lsu_rdata),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata)
    );

endmodule

// File: doc/el2_dccm_port_arb.md
Name: el2_dccm_port_arb

Overview:
- Two-requester arbiter and sequencer in front of the DCCM lo-bank port of the memory wrapper.
- Shares the single-cycle DCCM between the LSU (default priority) and DMA (starvation-protected).
- Tracks outstanding reads and steers the returned data to the requester that issued them.
- Sits between the LSU/DMA slave logic and the memory wrapper's dccm_* ports.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DCCM_FDATA_WIDTH, 39, data+ECC width per access.
- DMA_STARVE_MAX, 8, consecutive blocked DMA request cycles before DMA is forced to win; legal range 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- lsu_req  in  1  LSU access request; held until lsu_gnt.
- lsu_wr  in  1  1=write, 0=read.
- lsu_addr  in  DCCM_BITS  LSU address.
- lsu_wdata  in  DCCM_FDATA_WIDTH  LSU write data.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  LSU read data valid.
- lsu_rdata  out  DCCM_FDATA_WIDTH  LSU read data.
- dma_req, dma_wr, dma_addr, dma_wdata  in  1/1/DCCM_BITS/DCCM_FDATA_WIDTH  same semantics for DMA.
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DCCM_FDATA_WIDTH  same semantics for DMA.
- dccm_wren, dccm_rden  out  1  DCCM strobes.
- dccm_wr_addr_lo, dccm_rd_addr_lo  out  DCCM_BITS  DCCM addresses.
- dccm_wr_data_lo  out  DCCM_FDATA_WIDTH  DCCM write data.
- dccm_rd_data_lo  in  DCCM_FDATA_WIDTH  DCCM read data; valid 1 cycle after dccm_rden.
- dma_starved  out  1  registered; high while the FSM is in DMA_PRI.

Behaviour:
- Grants are combinational from the current requests and state; at most one grant per cycle. The granted request drives the dccm_* ports in the same cycle.
- Write grant: dccm_wren=1. Read grant: dccm_rden=1. The non-granted side holds its request.
- FSM, 2 states:
  - NORM: LSU wins when both request.
  - DMA_PRI: DMA wins when both request.
  - NORM->DMA_PRI when starve_cnt reaches DMA_STARVE_MAX-1 and DMA is blocked this cycle.
  - DMA_PRI->NORM on dma_gnt, or on dma_req deasserting.
- starve_cnt, 8-bit:
  - increments each cycle dma_req && !dma_gnt; saturates at DMA_STARVE_MAX.
  - clears on dma_gnt or !dma_req.
- Read return:
  - rd_pend_q <= dccm_rden; rd_own_q <= DMA-was-granted.
  - Next cycle: lsu_rvalid = rd_pend_q && !rd_own_q; dma_rvalid = rd_pend_q && rd_own_q.
  - lsu_rdata and dma_rdata are both driven from dccm_rd_data_lo, gated to 0 when the matching rvalid is low.
- Back-to-back reads from alternating owners are fully pipelined: one grant per cycle, and each return is tagged correctly.
- Write followed by read to the same address in the next cycle returns the new data; the DCCM itself guarantees this, so the arbiter adds no hazard logic.
- Reset: FSM=NORM, starve_cnt=0, rd_pend_q=0, rd_own_q=0.
  - All grant, rvalid and DCCM strobe outputs are 0 while rst=1.
  - dccm addresses and data outputs are 0 while rst=1.
- Reset asserted with a read outstanding: the return is dropped and no rvalid pulses after reset.
- Idle (no requests): all strobes 0; addresses hold 0.

Optional Feature:
- Macro: DCCM_ARB_DMA_LOCK_EN.
- With the macro defined:
  - Input dma_lock (1 bit) is present, together with a third FSM state DMA_LOCK.
  - A DMA grant with dma_lock=1 enters DMA_LOCK.
  - In DMA_LOCK: DMA always wins and lsu_gnt=0. The state exits to NORM when dma_lock=0 or after 16 locked cycles, whichever comes first.
  - After a timeout exit, LSU wins the next contested cycle.
- Without the macro: no dma_lock port, no DMA_LOCK state; behaviour is exactly as above.

Decomposition:
- Shared package el2_dccm_arb_pkg holds:
  - the FSM state enum (NORM, DMA_PRI, DMA_LOCK);
  - an owner enum (OWN_LSU, OWN_DMA);
  - the lock-timeout constant DMA_LOCK_MAX=16.
- One natural sub-module: el2_dccm_arb_rdtrk, the read-return tracker (rd_pend_q/rd_own_q plus rvalid/rdata steering).

Test Plan:
- Reset mid-read: LSU read granted, rst=1 the next cycle -> lsu_rvalid stays 0; after reset all outputs are 0 and the FSM is NORM.
- Both request every cycle, DMA_STARVE_MAX=8 -> LSU granted in cycles 0-7, DMA granted in cycle 8, dma_starved=1 in cycle 8 only, LSU granted in cycle 9.
- LSU write addr 0x0040 data 0x12345678A, then DMA read addr 0x0040 -> dccm_wren then dccm_rden; dma_rvalid=1 with dma_rdata=0x12345678A; lsu_rvalid=0.
- Alternating reads, LSU addr 0x10 then DMA addr 0x20 in consecutive cycles -> rvalid pulses return in issue order, each carrying its own address's data.
- DMA request drops at starve_cnt=5 -> counter clears; no forced grant follows.
- (DCCM_ARB_DMA_LOCK_EN) dma_lock held for 20 cycles with LSU requesting -> LSU blocked for 16 cycles, then granted in the next cycle.
